// File: rtl/conv_tile_scheduler.sv
// Layer sequencer for CONV_ACC: issues one pass per output-channel tile and
// generates the ifm/weight byte addresses, with beat-count and watchdog checks.
module conv_tile_scheduler #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TILE_W   = 8,
  parameter int unsigned IFM_UNIT = 7904,
  parameter int unsigned WGT_UNIT = 13312,
  parameter int unsigned TIMEOUT  = 2000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              layer_start,
  input  logic              layer_abort,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [1:0]        layer_ci,
  input  logic [1:0]        layer_co,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] wgt_base,
  output logic              start_conv,
  output logic [1:0]        cfg_ci,
  output logic [1:0]        cfg_co,
  input  logic              ifm_read,
  input  logic              wgt_read,
  input  logic              end_conv,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] wgt_addr,
  output logic [TILE_W-1:0] tile_idx,
  output logic              busy,
  output logic              layer_done,
  output logic              err_len,
  output logic              err_timeout,
  output logic              err_proto
);

  // state    | meaning
  // S_IDLE   | waiting for layer_start
  // S_LAUNCH | start_conv pulse out, ifm address reloaded
  // S_RUN    | CONV_ACC pass in progress, addresses follow read beats
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

  state_t            state;
  logic [TILE_W-1:0] num_tiles_q;
  logic [ADDR_W-1:0] ifm_base_q;
  logic [31:0]       ifm_cnt, wgt_cnt, wdog;

  logic [31:0] ifm_cnt_nxt, wgt_cnt_nxt, ci_n, co_n, ifm_exp, wgt_exp;
  logic        len_ok, last_tile, wdog_fire, proto_hit;

  always_comb begin
    ifm_cnt_nxt = ifm_cnt + 32'(ifm_read);
    wgt_cnt_nxt = wgt_cnt + 32'(wgt_read);
    ci_n        = 32'(cfg_ci) + 32'd1;
    co_n        = 32'(cfg_co) + 32'd1;
    ifm_exp     = ci_n * IFM_UNIT;
    wgt_exp     = ci_n * co_n * WGT_UNIT;
    len_ok      = (ifm_cnt_nxt == ifm_exp) && (wgt_cnt_nxt == wgt_exp);
    last_tile   = (tile_idx == num_tiles_q - TILE_W'(1));
    wdog_fire   = (TIMEOUT != 0) && (wdog == TIMEOUT - 1);
    proto_hit   = (state != S_RUN) && (ifm_read || wgt_read || end_conv);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      num_tiles_q <= '0;
      ifm_base_q  <= '0;
      ifm_cnt     <= '0;
      wgt_cnt     <= '0;
      wdog        <= '0;
      start_conv  <= 1'b0;
      cfg_ci      <= '0;
      cfg_co      <= '0;
      ifm_addr    <= '0;
      wgt_addr    <= '0;
      tile_idx    <= '0;
      busy        <= 1'b0;
      layer_done  <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_proto   <= 1'b0;
    end else begin
      start_conv <= 1'b0;
      layer_done <= 1'b0;
      if (layer_abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (layer_start) begin
              num_tiles_q <= num_tiles;
              ifm_base_q  <= ifm_base;
              cfg_ci      <= layer_ci;
              cfg_co      <= layer_co;
              tile_idx    <= '0;
              err_len     <= 1'b0;
              err_timeout <= 1'b0;
              err_proto   <= 1'b0;
              if (num_tiles == '0) begin
                layer_done <= 1'b1;
              end else begin
                state      <= S_LAUNCH;
                start_conv <= 1'b1;
                busy       <= 1'b1;
                ifm_addr   <= ifm_base;
                wgt_addr   <= wgt_base;
                ifm_cnt    <= '0;
                wgt_cnt    <= '0;
                wdog       <= '0;
              end
            end
          end
          S_LAUNCH: state <= S_RUN;
          S_RUN: begin
            if (ifm_read) begin
              ifm_addr <= ifm_addr + ADDR_W'(8);
              ifm_cnt  <= ifm_cnt_nxt;
            end
            if (wgt_read) begin
              wgt_addr <= wgt_addr + ADDR_W'(4);
              wgt_cnt  <= wgt_cnt_nxt;
            end
            wdog <= wdog + 32'd1;
            if (end_conv) begin
              if (!len_ok) err_len <= 1'b1;
              if (last_tile) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                layer_done <= 1'b1;
              end else begin
                // weights run on contiguously across tiles; only ifm restarts
                tile_idx   <= tile_idx + TILE_W'(1);
                state      <= S_LAUNCH;
                start_conv <= 1'b1;
                ifm_addr   <= ifm_base_q;
                ifm_cnt    <= '0;
                wgt_cnt    <= '0;
                wdog       <= '0;
              end
            end else if (wdog_fire) begin
              err_timeout <= 1'b1;
              state       <= S_IDLE;
              busy        <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
      if (proto_hit) err_proto <= 1'b1;
    end
  end

endmodule
